unidade_controle: RTL and testbench

Hardwired Moore control unit for the 8-bit TI170 CPU. It sits directly upstream of the `caminho_dados` datapath. Each cycle it drives the datapath's bus-mux selects, ALU select, register load strobes and memory write enable, sequencing fetch, decode and execute. It captures ALU flags into an internal condition-code register, which it uses for conditional branches.

---
 rtl/unidade_controle.sv | 272 +++++++++++++++++++++++++++
 tb/tb_unidade_controle.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// -----------------------------------------------------------------------------
// unidade_controle
//
// Hardwired Moore control unit for the 8-bit TI170 CPU. It drives the
// caminho_dados datapath through fetch, decode and execute. It also keeps a
// 4-bit condition-code register (CCR) that the ALU instructions load and the
// conditional branches read.
//
// Ports
//   clock      in   system clock, rising-edge active
//   reset      in   synchronous, active-high; forces every output to 0
//   ir_in      in   [7:0] current IR contents (the opcode being executed)
//   alu_flags  in   [3:0] ALU flags {N,Z,V,C} for the selected operation
//   bus1_sel   out  [1:0] 00 = PC, 01 = R1, 10 = R2
//   bus2_sel   out  [1:0] 00 = alu_out, 01 = bus1, 10 = dado_mem
//   alu_sel    out  [3:0] 0 ADD, 1 SUB, 2 AND, 3 OR, 4 INC(R1)
//   pc_load    out  PC  <= bus2
//   pc_inc     out  PC  <= PC + 1
//   ir_load    out  IR  <= bus2
//   mar_load   out  MAR <= bus2
//   r1_load    out  R1  <= bus2
//   r2_load    out  R2  <= bus2
//   r3_load    out  R3  <= bus2
//   mem_we     out  memory write of R1/R2 (via bus1) at MAR
//   halted     out  high while in HALT
// -----------------------------------------------------------------------------
module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ir_in,
  input  logic [3:0] alu_flags,
  output logic [1:0] bus1_sel,
  output logic [1:0] bus2_sel,
  output logic [3:0] alu_sel,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       ir_load,
  output logic       mar_load,
  output logic       r1_load,
  output logic       r2_load,
  output logic       r3_load,
  output logic       mem_we,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH_0,
    S_FETCH_1,
    S_FETCH_2,
    S_DECODE,
    S_E0,
    S_E1,
    S_E2,
    S_E3,
    S_HALT
  } state_e;

  // Instruction classes: every opcode in a class walks the same state path.
  typedef enum logic [2:0] {
    OP_NOP,
    OP_LD_IMM,
    OP_LD_DIR,
    OP_ST_DIR,
    OP_ALU,
    OP_TR3,
    OP_BRANCH,
    OP_HALT
  } op_class_e;

  // Bus select encodings
  localparam logic [1:0] B1_PC  = 2'b00;
  localparam logic [1:0] B1_R1  = 2'b01;
  localparam logic [1:0] B1_R2  = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00;
  localparam logic [1:0] B2_B1  = 2'b01;
  localparam logic [1:0] B2_MEM = 2'b10;

  state_e     state_q, state_d;
  logic [3:0] ccr_q, ccr_d;

  op_class_e  op_class;
  logic       use_r2;       // LDB/STB variants target R2 instead of R1
  logic       br_taken;     // BRA always; BEQ on CCR.Z; BMI on CCR.N

  // ---------------------------------------------------------------------------
  // Opcode classification. The IR is stable from DECODE to the end of the
  // instruction, so decoding it combinationally in every state is safe.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    op_class = OP_NOP;
    use_r2   = 1'b0;
    br_taken = 1'b0;
    case (ir_in)
      8'h86: op_class = OP_LD_IMM;
      8'h88: begin op_class = OP_LD_IMM; use_r2 = 1'b1; end
      8'h87: op_class = OP_LD_DIR;
      8'h89: begin op_class = OP_LD_DIR; use_r2 = 1'b1; end
      8'h96: op_class = OP_ST_DIR;
      8'h97: begin op_class = OP_ST_DIR; use_r2 = 1'b1; end
      8'h42, 8'h43, 8'h44, 8'h45, 8'h46: op_class = OP_ALU;
      8'h50: op_class = OP_TR3;
      8'h20: begin op_class = OP_BRANCH; br_taken = 1'b1;     end
      8'h21: begin op_class = OP_BRANCH; br_taken = ccr_q[2]; end
      8'h22: begin op_class = OP_BRANCH; br_taken = ccr_q[3]; end
      8'hFF: op_class = OP_HALT;
      default: op_class = OP_NOP;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH_0: state_d = S_FETCH_1;
      S_FETCH_1: state_d = S_FETCH_2;
      S_FETCH_2: state_d = S_DECODE;
      S_DECODE: begin
        case (op_class)
          OP_NOP:  state_d = S_FETCH_0;
          OP_HALT: state_d = S_HALT;
          default: state_d = S_E0;
        endcase
      end
      S_E0: begin
        case (op_class)
          OP_LD_IMM, OP_LD_DIR, OP_ST_DIR: state_d = S_E1;
          OP_BRANCH: state_d = br_taken ? S_E1 : S_FETCH_0;
          default:   state_d = S_FETCH_0;
        endcase
      end
      S_E1: begin
        case (op_class)
          OP_LD_IMM, OP_LD_DIR, OP_ST_DIR: state_d = S_E2;
          default: state_d = S_FETCH_0;
        endcase
      end
      S_E2: begin
        case (op_class)
          OP_LD_DIR, OP_ST_DIR: state_d = S_E3;
          default: state_d = S_FETCH_0;
        endcase
      end
      S_E3:    state_d = S_FETCH_0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH_0;
    endcase
  end

  // The CCR only changes at the end of an ALU instruction's single execute
  // step, so a branch always sees the flags of the last ALU op.
  always_comb begin
    ccr_d = ccr_q;
    if (state_q == S_E0 && op_class == OP_ALU) ccr_d = alu_flags;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values and simulation matches the hardware.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH_0;
      ccr_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      ccr_q   <= ccr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Moore output decode. Reset gates every output so no strobe can reach the
  // datapath in a cycle where reset is being sampled.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus1_sel = B1_PC;
    bus2_sel = B2_ALU;
    alu_sel  = 4'h0;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    ir_load  = 1'b0;
    mar_load = 1'b0;
    r1_load  = 1'b0;
    r2_load  = 1'b0;
    r3_load  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH_0: begin                 // MAR <= PC
          bus1_sel = B1_PC;
          bus2_sel = B2_B1;
          mar_load = 1'b1;
        end
        S_FETCH_1: pc_inc = 1'b1;
        S_FETCH_2: begin                 // IR <= mem[MAR]
          bus2_sel = B2_MEM;
          ir_load  = 1'b1;
        end
        S_E0: begin
          case (op_class)
            OP_LD_IMM, OP_LD_DIR, OP_ST_DIR: begin   // operand fetch: MAR <= PC
              bus1_sel = B1_PC;
              bus2_sel = B2_B1;
              mar_load = 1'b1;
            end
            OP_ALU: begin
              // Opcodes 0x42..0x46 map onto ALU selects 0..4.
              alu_sel  = ir_in[3:0] - 4'h2;
              bus2_sel = B2_ALU;
              r1_load  = 1'b1;
            end
            OP_TR3: begin
              bus1_sel = B1_R1;
              bus2_sel = B2_B1;
              r3_load  = 1'b1;
            end
            OP_BRANCH: begin
              if (br_taken) begin
                bus1_sel = B1_PC;
                bus2_sel = B2_B1;
                mar_load = 1'b1;
              end else begin
                pc_inc = 1'b1;           // step over the unused target byte
              end
            end
            default: ;
          endcase
        end
        S_E1: begin
          case (op_class)
            OP_LD_IMM, OP_LD_DIR, OP_ST_DIR: pc_inc = 1'b1;
            OP_BRANCH: begin             // only reached when taken
              bus2_sel = B2_MEM;
              pc_load  = 1'b1;
            end
            default: ;
          endcase
        end
        S_E2: begin
          bus2_sel = B2_MEM;
          case (op_class)
            OP_LD_IMM: begin
              r1_load = ~use_r2;
              r2_load = use_r2;
            end
            OP_LD_DIR, OP_ST_DIR: mar_load = 1'b1;   // MAR <= direct address
            default: ;
          endcase
        end
        S_E3: begin
          case (op_class)
            OP_LD_DIR: begin
              bus2_sel = B2_MEM;
              r1_load  = ~use_r2;
              r2_load  = use_r2;
            end
            OP_ST_DIR: begin
              bus1_sel = use_r2 ? B1_R2 : B1_R1;
              mem_we   = 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle
//
// Directed bench for the TI170 control unit. Each instruction is run cycle by
// cycle with the opcode presented on ir_in. The sampled output vector of every
// cycle is compared with hand-written expected vectors.
// Vector layout: {bus1_sel, bus2_sel, alu_sel, pc_load, pc_inc, ir_load,
//                 mar_load, r1_load, r2_load, r3_load, mem_we, halted}
// -----------------------------------------------------------------------------
module tb_unidade_controle;

  typedef logic [16:0] vec_t;

  logic       clock;
  logic       reset;
  logic [7:0] ir_in;
  logic [3:0] alu_flags;
  logic [1:0] bus1_sel, bus2_sel;
  logic [3:0] alu_sel;
  logic       pc_load, pc_inc, ir_load, mar_load;
  logic       r1_load, r2_load, r3_load, mem_we, halted;

  int errors = 0;
  int checks = 0;

  vec_t obsq[$];
  vec_t expq[$];

  unidade_controle dut (
    .clock     (clock),
    .reset     (reset),
    .ir_in     (ir_in),
    .alu_flags (alu_flags),
    .bus1_sel  (bus1_sel),
    .bus2_sel  (bus2_sel),
    .alu_sel   (alu_sel),
    .pc_load   (pc_load),
    .pc_inc    (pc_inc),
    .ir_load   (ir_load),
    .mar_load  (mar_load),
    .r1_load   (r1_load),
    .r2_load   (r2_load),
    .r3_load   (r3_load),
    .mem_we    (mem_we),
    .halted    (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe one-hots within the low 9 bits of the vector
  localparam logic [8:0] S_NONE  = 9'h000;
  localparam logic [8:0] S_PCLD  = 9'h100;
  localparam logic [8:0] S_PCINC = 9'h080;
  localparam logic [8:0] S_IR    = 9'h040;
  localparam logic [8:0] S_MAR   = 9'h020;
  localparam logic [8:0] S_R1    = 9'h010;
  localparam logic [8:0] S_R2    = 9'h008;
  localparam logic [8:0] S_R3    = 9'h004;
  localparam logic [8:0] S_WE    = 9'h002;
  localparam logic [8:0] S_HLT   = 9'h001;

  localparam vec_t V_ZERO = 17'h0;
  localparam vec_t V_F0   = {2'd0, 2'd1, 4'd0, S_MAR};
  localparam vec_t V_F1   = {2'd0, 2'd0, 4'd0, S_PCINC};
  localparam vec_t V_F2   = {2'd0, 2'd2, 4'd0, S_IR};
  localparam vec_t V_DEC  = {2'd0, 2'd0, 4'd0, S_NONE};
  localparam vec_t V_HALT = {2'd0, 2'd0, 4'd0, S_HLT};

  function automatic vec_t mk(input logic [1:0] b1, input logic [1:0] b2,
                              input logic [3:0] alu, input logic [8:0] s);
    return {b1, b2, alu, s};
  endfunction

  function automatic vec_t obs();
    return {bus1_sel, bus2_sel, alu_sel, pc_load, pc_inc, ir_load, mar_load,
            r1_load, r2_load, r3_load, mem_we, halted};
  endfunction

  // Advance one clock and land on the falling edge, where inputs are driven.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Run n cycles of an instruction, recording the outputs of each cycle.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] flags, input int n);
    for (int i = 0; i < n; i++) begin
      ir_in     = op;
      alu_flags = flags;
      #1;
      obsq.push_back(obs());
      tick();
    end
  endtask

  // Record the current cycle without advancing (the next instruction's FETCH_0).
  task automatic sample_now();
    #1;
    obsq.push_back(obs());
  endtask

  task automatic push_fetch();
    expq.push_back(V_F0);
    expq.push_back(V_F1);
    expq.push_back(V_F2);
    expq.push_back(V_DEC);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] ops [0:2];
    ops[0] = 8'hFF; ops[1] = 8'h86; ops[2] = 8'h42;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ir_in     = ops[i];
      alu_flags = 4'hF;
      #1;
      checks++;
      if (obs() !== V_ZERO) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %05h expected %05h", i, obs(), V_ZERO);
      end
      tick();
    end
    // Release reset, then LDA #imm: r1_load in cycle 6, FETCH_0 in cycle 7.
    reset = 1'b0;
    push_fetch();
    expq.push_back(V_F0);
    expq.push_back(V_F1);
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_R1));
    run_instr(8'h86, 4'h0, 7);
    expq.push_back(V_F0);
    sample_now();
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++;
        $display("FAIL reset_lda_imm cycle %0d: got %05h expected %05h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Loads with garbage on alu_flags; a following BEQ must not be taken since
  // the CCR was cleared by reset and loads leave it alone.
  task automatic test_loads();
    push_fetch();
    expq.push_back(V_F0); expq.push_back(V_F1);
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_R2));
    run_instr(8'h88, 4'hF, 7);
    push_fetch();
    expq.push_back(V_F0); expq.push_back(V_F1);
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_MAR));
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_R1));
    run_instr(8'h87, 4'hF, 8);
    push_fetch();
    expq.push_back(V_F0); expq.push_back(V_F1);
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_MAR));
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_R2));
    run_instr(8'h89, 4'hF, 8);
    push_fetch();
    expq.push_back(mk(2'd0, 2'd0, 4'd0, S_PCINC));
    run_instr(8'h21, 4'hF, 5);
    expq.push_back(V_F0);
    sample_now();
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++;
        $display("FAIL loads cycle %0d: got %05h expected %05h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_store();
    int we_cycles;
    push_fetch();
    expq.push_back(V_F0); expq.push_back(V_F1);
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_MAR));
    expq.push_back(mk(2'd1, 2'd0, 4'd0, S_WE));
    run_instr(8'h96, 4'h0, 8);
    push_fetch();
    expq.push_back(V_F0); expq.push_back(V_F1);
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_MAR));
    expq.push_back(mk(2'd2, 2'd0, 4'd0, S_WE));
    run_instr(8'h97, 4'h0, 8);
    expq.push_back(V_F0);
    sample_now();
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++;
        $display("FAIL store cycle %0d: got %05h expected %05h", i, obsq[i], expq[i]);
      end
    end
    we_cycles = 0;
    foreach (obsq[i]) if (obsq[i][1]) we_cycles++;
    checks++;
    if (we_cycles !== 2) begin
      errors++;
      $display("FAIL store_we_width: got %0d write cycles expected 2", we_cycles);
    end
    obsq.delete(); expq.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu_branch();
    // SUB with Z, BEQ taken
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd1, S_R1));
    run_instr(8'h43, 4'b0100, 5);
    push_fetch(); expq.push_back(V_F0); expq.push_back(mk(2'd0, 2'd2, 4'd0, S_PCLD));
    run_instr(8'h21, 4'b0000, 6);
    // ADD clears flags, BEQ not taken
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd0, S_R1));
    run_instr(8'h42, 4'b0000, 5);
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd0, S_PCINC));
    run_instr(8'h21, 4'b0100, 5);
    // AND sets N: BMI taken, BEQ not taken
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd2, S_R1));
    run_instr(8'h44, 4'b1000, 5);
    push_fetch(); expq.push_back(V_F0); expq.push_back(mk(2'd0, 2'd2, 4'd0, S_PCLD));
    run_instr(8'h22, 4'b0000, 6);
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd0, S_PCINC));
    run_instr(8'h21, 4'b0000, 5);
    // OR sets only C: BMI not taken
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd3, S_R1));
    run_instr(8'h45, 4'b0001, 5);
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd0, S_PCINC));
    run_instr(8'h22, 4'b1111, 5);
    // INCA sets Z; TR3 leaves CCR; BEQ taken; BRA
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd4, S_R1));
    run_instr(8'h46, 4'b0100, 5);
    push_fetch(); expq.push_back(mk(2'd1, 2'd1, 4'd0, S_R3));
    run_instr(8'h50, 4'b0000, 5);
    push_fetch(); expq.push_back(V_F0); expq.push_back(mk(2'd0, 2'd2, 4'd0, S_PCLD));
    run_instr(8'h21, 4'b0000, 6);
    push_fetch(); expq.push_back(V_F0); expq.push_back(mk(2'd0, 2'd2, 4'd0, S_PCLD));
    run_instr(8'h20, 4'b0000, 6);
    expq.push_back(V_F0);
    sample_now();
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++;
        $display("FAIL alu_branch cycle %0d: got %05h expected %05h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_illegal();
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd1, S_R1));
    run_instr(8'h43, 4'b0100, 5);
    push_fetch();
    run_instr(8'h7E, 4'b0000, 4);
    push_fetch();
    run_instr(8'h00, 4'b0000, 4);
    // CCR.Z must survive the illegal opcodes
    push_fetch(); expq.push_back(V_F0); expq.push_back(mk(2'd0, 2'd2, 4'd0, S_PCLD));
    run_instr(8'h21, 4'b0000, 6);
    expq.push_back(V_F0);
    sample_now();
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %05h expected %05h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  // ---------------------------------------------------------------------------
  // HLT is sticky for 22 cycles even with a new opcode on ir_in; reset then
  // zeroes the outputs and restarts at FETCH_0 with a cleared CCR.
  task automatic test_halt();
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd1, S_R1));
    run_instr(8'h43, 4'b0100, 5);
    push_fetch();
    run_instr(8'hFF, 4'b0000, 4);
    for (int i = 0; i < 22; i++) expq.push_back(V_HALT);
    run_instr(8'h86, 4'b0000, 22);
    reset = 1'b1;
    expq.push_back(V_ZERO);
    run_instr(8'h86, 4'b0000, 1);
    reset = 1'b0;
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd0, S_PCINC));
    run_instr(8'h21, 4'b0000, 5);
    expq.push_back(V_F0);
    sample_now();
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++;
        $display("FAIL halt cycle %0d: got %05h expected %05h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Reset pulsed in the E2 cycle of LDA dir: outputs 0 in that cycle, no E3,
  // FETCH_0 next, and the CCR (Z set beforehand) is cleared.
  task automatic test_reset_mid();
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd1, S_R1));
    run_instr(8'h43, 4'b0100, 5);
    push_fetch(); expq.push_back(V_F0); expq.push_back(V_F1);
    run_instr(8'h87, 4'b0000, 6);
    reset = 1'b1;
    expq.push_back(V_ZERO);
    run_instr(8'h87, 4'b0000, 1);
    reset = 1'b0;
    push_fetch(); expq.push_back(mk(2'd0, 2'd0, 4'd0, S_PCINC));
    run_instr(8'h21, 4'b0000, 5);
    push_fetch(); expq.push_back(V_F0); expq.push_back(V_F1);
    expq.push_back(mk(2'd0, 2'd2, 4'd0, S_R1));
    run_instr(8'h86, 4'b0000, 7);
    expq.push_back(V_F0);
    sample_now();
    for (int i = 0; i < expq.size(); i++) begin
      checks++;
      if (obsq[i] !== expq[i]) begin
        errors++;
        $display("FAIL reset_mid cycle %0d: got %05h expected %05h", i, obsq[i], expq[i]);
      end
    end
    obsq.delete(); expq.delete();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    reset     = 1'b1;
    ir_in     = 8'h00;
    alu_flags = 4'h0;
    @(negedge clock);
    test_reset();
    test_loads();
    test_store();
    test_alu_branch();
    test_illegal();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
